// File: rtl/led_scroller_pkg.sv
// rtl/led_scroller_pkg.sv - mode/direction encodings and LED pattern helper
// Purpose: shared types for the LED scroller and the (mode, pos) -> led map.
// Contents: mode_e, dir_e, led_pattern().
package led_scroller_pkg;

  typedef enum logic [1:0] {
    MODE_ROT_L  = 2'd0,
    MODE_ROT_R  = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_FILL   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // 32-bit result; callers truncate to their LED width. Fill lights [pos:0]
  // by shifting an all-ones word right so no wider temporary is needed.
  function automatic logic [31:0] led_pattern(input mode_e mode, input logic [4:0] pos);
    if (mode == MODE_FILL) begin
      return 32'hFFFF_FFFF >> (5'd31 - pos);
    end
    return 32'd1 << pos;
  endfunction

endpackage

// File: rtl/led_scroller_gen_if.sv
// rtl/led_scroller_gen_if.sv - control/status bundle of the LED scroller
// Purpose: groups the pattern controls and the LED outputs.
// master: drives mode/speed/pause/step, observes led/pos/tick.
// slave : the scroller itself.
interface led_scroller_gen_if #(
  parameter int LED_W = 8
);
  logic [1:0]               mode;
  logic [1:0]               speed;
  logic                     pause;
  logic                     step;
  logic [LED_W-1:0]         led;
  logic [$clog2(LED_W)-1:0] pos;
  logic                     tick;

  modport master (output mode, speed, pause, step, input led, pos, tick);
  modport slave  (input mode, speed, pause, step, output led, pos, tick);
endinterface

// File: rtl/scroll_prescaler.sv
// rtl/scroll_prescaler.sv - step-period prescaler with pause/single-step
// Ports: clk, reset (sync, active-high), speed (period = max(CNT_TICK>>speed,1)),
//        pause (freeze count), step (advance while paused), clr (restart count),
//        adv (combinational advance request for the current cycle).
module scroll_prescaler #(
  parameter int               CNT_W    = 27,
  parameter logic [CNT_W-1:0] CNT_TICK = 27'd100_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] speed,
  input  logic       pause,
  input  logic       step,
  input  logic       clr,
  output logic       adv
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] shifted;
  logic [CNT_W-1:0] period_m1;

  always_comb begin
    shifted   = CNT_TICK >> speed;
    // A zero shifted period collapses to 1 cycle.
    period_m1 = (shifted == '0) ? '0 : shifted - CNT_W'(1);
    // >= so a mid-count speed-up fires immediately instead of wrapping.
    adv       = pause ? step : (cnt_q >= period_m1);
    cnt_d     = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!pause) begin
      cnt_d = adv ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_scroller_gen.sv
// rtl/led_scroller_gen.sv - four-pattern LED scroller with speed/pause/step
// Ports: clk, reset (sync, active-high), bus (slave): mode, speed, pause, step
//        in; led (pattern), pos (head index), tick (new-value pulse) out.
module led_scroller_gen
  import led_scroller_pkg::*;
#(
  parameter int               LED_W    = 8,
  parameter int               CNT_W    = 27,
  parameter logic [CNT_W-1:0] CNT_TICK = 27'd100_000_000
) (
  input  logic                clk,
  input  logic                reset,
  led_scroller_gen_if.slave   bus
);

  localparam int               POS_W   = $clog2(LED_W);
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(LED_W - 1);
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [POS_W-1:0] pos_q, pos_d;
  dir_e             dir_q, dir_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             tick_q, tick_d;
  mode_e            mode_q, mode_d;
  logic             mode_chg;
  logic             adv;

  // A mode change restarts the prescaler so the new pattern gets a full period.
  assign mode_chg = (mode_e'(bus.mode) != mode_q);

  scroll_prescaler #(
    .CNT_W    (CNT_W),
    .CNT_TICK (CNT_TICK)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .speed (bus.speed),
    .pause (bus.pause),
    .step  (bus.step),
    .clr   (mode_chg),
    .adv   (adv)
  );

  always_comb begin
    pos_d  = pos_q;
    dir_d  = dir_q;
    led_d  = led_q;
    tick_d = 1'b0;
    mode_d = mode_q;
    if (mode_chg) begin
      pos_d  = '0;
      dir_d  = DIR_UP;
      led_d  = LED_W'(1);
      mode_d = mode_e'(bus.mode);
    end else if (adv) begin
      tick_d = 1'b1;
      case (mode_q)
        MODE_ROT_R: pos_d = (pos_q == '0) ? POS_MAX : pos_q - POS_ONE;
        MODE_BOUNCE: begin
          // Turn around at the ends so end LEDs are lit for a single period.
          if (dir_q == DIR_UP) begin
            if (pos_q == POS_MAX) begin
              dir_d = DIR_DOWN;
              pos_d = POS_MAX - POS_ONE;
            end else begin
              pos_d = pos_q + POS_ONE;
            end
          end else begin
            if (pos_q == '0) begin
              dir_d = DIR_UP;
              pos_d = POS_ONE;
            end else begin
              pos_d = pos_q - POS_ONE;
            end
          end
        end
        default: pos_d = (pos_q == POS_MAX) ? '0 : pos_q + POS_ONE;
      endcase
      led_d = LED_W'(led_pattern(mode_q, 5'(pos_d)));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q  <= '0;
      dir_q  <= DIR_UP;
      led_q  <= LED_W'(1);
      tick_q <= 1'b0;
      mode_q <= mode_e'(bus.mode);
    end else begin
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      led_q  <= led_d;
      tick_q <= tick_d;
      mode_q <= mode_d;
    end
  end

  assign bus.led  = led_q;
  assign bus.pos  = pos_q;
  assign bus.tick = tick_q;

endmodule

// File: tb/tb_led_scroller_gen.sv
// tb/tb_led_scroller_gen.sv - directed self-checking bench for led_scroller_gen
module tb_led_scroller_gen;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  led_scroller_gen_if #(.LED_W(8)) bus ();

  led_scroller_gen #(
    .LED_W    (8),
    .CNT_W    (27),
    .CNT_TICK (27'd100)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input int max_cyc, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (bus.tick !== 1'b1 && n < max_cyc);
    chk("tick_seen", {31'd0, bus.tick}, 32'd1);
  endtask

  logic [7:0] bounce_exp [15];
  logic [7:0] fill_exp   [8];
  logic [7:0] step_exp   [3];
  int n;
  int ticks_seen;

  initial begin
    checks = 0;
    errors = 0;
    bounce_exp = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                   8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    fill_exp   = '{8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
    step_exp   = '{8'h08, 8'h10, 8'h20};

    // Reset state
    reset     = 1'b1;
    bus.mode  = 2'd0;
    bus.speed = 2'd0;
    bus.pause = 1'b0;
    bus.step  = 1'b0;
    repeat (3) cyc();
    chk("rst_led",  32'(bus.led),  32'h01);
    chk("rst_pos",  32'(bus.pos),  32'd0);
    chk("rst_tick", 32'(bus.tick), 32'd0);
    reset = 1'b0;

    // Rotate left: first tick at 100, then 100-cycle spacing, wrap after 8
    wait_tick(1000, n);
    chk("rotl_first_lat", n, 100);
    chk("rotl_first_led", 32'(bus.led), 32'h02);
    chk("rotl_first_pos", 32'(bus.pos), 32'd1);
    for (int i = 2; i <= 8; i++) begin
      wait_tick(1000, n);
      chk("rotl_spacing", n, 100);
      chk("rotl_led", 32'(bus.led), 32'd1 << (i % 8));
    end

    // Bounce
    bus.mode = 2'd2;
    cyc();
    chk("bnc_chg_led",  32'(bus.led),  32'h01);
    chk("bnc_chg_pos",  32'(bus.pos),  32'd0);
    chk("bnc_chg_tick", 32'(bus.tick), 32'd0);
    for (int i = 0; i < 15; i++) begin
      wait_tick(1000, n);
      chk("bnc_spacing", n, 100);
      chk("bnc_led", 32'(bus.led), 32'(bounce_exp[i]));
      chk("bnc_pos_le7", {31'd0, (bus.pos <= 3'd7)}, 32'd1);
    end

    // Fill
    bus.mode = 2'd3;
    cyc();
    chk("fill_chg_led", 32'(bus.led), 32'h01);
    for (int i = 0; i < 8; i++) begin
      wait_tick(1000, n);
      chk("fill_spacing", n, 100);
      chk("fill_led", 32'(bus.led), 32'(fill_exp[i]));
    end

    // Rotate right with speed raised 0->3 at cnt=50
    bus.mode = 2'd1;
    cyc();
    chk("rotr_chg_led", 32'(bus.led), 32'h01);
    repeat (49) cyc();
    bus.speed = 2'd3;
    cyc();
    chk("spd_tick_now", 32'(bus.tick), 32'd1);
    chk("spd_led",      32'(bus.led),  32'h80);
    chk("spd_pos",      32'(bus.pos),  32'd7);
    wait_tick(1000, n);
    chk("spd_spacing1", n, 12);
    chk("spd_led2", 32'(bus.led), 32'h40);
    wait_tick(1000, n);
    chk("spd_spacing2", n, 12);
    chk("spd_led3", 32'(bus.led), 32'h20);

    // Pause mid-period in rotate left
    bus.mode  = 2'd0;
    bus.speed = 2'd0;
    cyc();
    chk("rotl2_chg_led", 32'(bus.led), 32'h01);
    wait_tick(1000, n);
    chk("rotl2_lat", n, 100);
    repeat (30) cyc();
    bus.pause  = 1'b1;
    ticks_seen = 0;
    for (int i = 0; i < 500; i++) begin
      cyc();
      if (bus.tick === 1'b1) ticks_seen++;
    end
    chk("pause_no_tick", ticks_seen, 0);
    chk("pause_led",     32'(bus.led), 32'h02);
    chk("pause_pos",     32'(bus.pos), 32'd1);
    bus.pause = 1'b0;
    wait_tick(1000, n);
    chk("unpause_remaining", n, 70);
    chk("unpause_led", 32'(bus.led), 32'h04);

    // Single steps while paused
    bus.pause = 1'b1;
    repeat (5) cyc();
    for (int i = 0; i < 3; i++) begin
      bus.step = 1'b1;
      cyc();
      bus.step = 1'b0;
      chk("step_tick", 32'(bus.tick), 32'd1);
      chk("step_led",  32'(bus.led),  32'(step_exp[i]));
      repeat (3) cyc();
      chk("step_tick_off", 32'(bus.tick), 32'd0);
    end
    chk("step_pos5", 32'(bus.pos), 32'd5);

    // Mode 0->2 while paused at pos 5
    bus.mode = 2'd2;
    cyc();
    chk("pchg_led",  32'(bus.led),  32'h01);
    chk("pchg_pos",  32'(bus.pos),  32'd0);
    chk("pchg_tick", 32'(bus.tick), 32'd0);

    // Step while running is ignored
    bus.pause = 1'b0;
    bus.step  = 1'b1;
    cyc();
    bus.step = 1'b0;
    chk("run_step_no_tick", 32'(bus.tick), 32'd0);
    wait_tick(1000, n);
    chk("run_step_lat", n, 99);
    chk("run_step_led", 32'(bus.led), 32'h02);

    // Reach pos 6 with dir down, then reset mid-period
    for (int i = 0; i < 7; i++) wait_tick(1000, n);
    chk("pre_rst_led", 32'(bus.led), 32'h40);
    repeat (40) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mrst_led",  32'(bus.led),  32'h01);
    chk("mrst_pos",  32'(bus.pos),  32'd0);
    chk("mrst_tick", 32'(bus.tick), 32'd0);
    wait_tick(1000, n);
    chk("mrst_lat", n, 100);
    chk("mrst_led_up", 32'(bus.led), 32'h02);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
